// File: rtl/seg_display_mux_pkg.sv
// Shared definitions for the seven-segment display multiplexer.
// Holds the active-low segment patterns for BCD digits (bit order
// {dp,g,f,e,d,c,b,a}), the active-low anode patterns for each digit
// position, the 2-bit digit-index encoding, and a helper that maps an
// index to its anode pattern.
package seg_display_mux_pkg;

  // Scan order: the rightmost digit (seconds units) is index 0.
  typedef enum logic [1:0] {
    IDX_S0 = 2'd0,
    IDX_S1 = 2'd1,
    IDX_M0 = 2'd2,
    IDX_M1 = 2'd3
  } digit_idx_t;

  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [7:0] SEG_0     = 8'hC0;
  localparam logic [7:0] SEG_1     = 8'hF9;
  localparam logic [7:0] SEG_2     = 8'hA4;
  localparam logic [7:0] SEG_3     = 8'hB0;
  localparam logic [7:0] SEG_4     = 8'h99;
  localparam logic [7:0] SEG_5     = 8'h92;
  localparam logic [7:0] SEG_6     = 8'h82;
  localparam logic [7:0] SEG_7     = 8'hF8;
  localparam logic [7:0] SEG_8     = 8'h80;
  localparam logic [7:0] SEG_9     = 8'h90;

  localparam logic [3:0] AN_S0  = 4'b1110;
  localparam logic [3:0] AN_S1  = 4'b1101;
  localparam logic [3:0] AN_M0  = 4'b1011;
  localparam logic [3:0] AN_M1  = 4'b0111;
  localparam logic [3:0] AN_OFF = 4'b1111;

  // Each pattern has exactly one low bit, so at most one digit is ever lit.
  function automatic logic [3:0] anode_of(input digit_idx_t idx);
    case (idx)
      IDX_S0:  return AN_S0;
      IDX_S1:  return AN_S1;
      IDX_M0:  return AN_M0;
      default: return AN_M1;
    endcase
  endfunction

endpackage

// File: rtl/seg_display_mux_if.sv
// Bundle between the stopwatch time source and the display driver.
//   m1, m0, s1, s0 : BCD digits (minutes tens/units, seconds tens/units)
//   adj            : 1 = adjust mode, the selected pair blinks
//   sel            : in adjust mode, 0 = minutes pair, 1 = seconds pair
//   seg            : active-low segments {dp,g,f,e,d,c,b,a}
//   ad             : active-low anode enables, ad[0] = rightmost digit
// master = time source side, slave = display driver side.
interface seg_display_mux_if;
  logic [3:0] m1;
  logic [3:0] m0;
  logic [3:0] s1;
  logic [3:0] s0;
  logic       adj;
  logic       sel;
  logic [7:0] seg;
  logic [3:0] ad;

  modport master (
    output m1, m0, s1, s0, adj, sel,
    input  seg, ad
  );

  modport slave (
    input  m1, m0, s1, s0, adj, sel,
    output seg, ad
  );
endinterface

// File: rtl/seg_display_mux_bcd_to_seg7.sv
// BCD to seven-segment decoder, purely combinational.
//   bcd : 4-bit digit; 10..15 are not valid BCD and give a blank digit
//   seg : active-low segments {dp,g,f,e,d,c,b,a}; dp is always off
module bcd_to_seg7
  import seg_display_mux_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [7:0] seg
);

  always_comb begin
    // NOTE: the output gets a default before the case so that no path
    // leaves it unassigned, which would otherwise infer a latch.
    seg = SEG_BLANK;
    case (bcd)
      4'd0:    seg = SEG_0;
      4'd1:    seg = SEG_1;
      4'd2:    seg = SEG_2;
      4'd3:    seg = SEG_3;
      4'd4:    seg = SEG_4;
      4'd5:    seg = SEG_5;
      4'd6:    seg = SEG_6;
      4'd7:    seg = SEG_7;
      4'd8:    seg = SEG_8;
      4'd9:    seg = SEG_9;
      default: seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/seg_display_mux.sv
// Time-multiplexed driver for a 4-digit common-anode seven-segment display.
// A refresh counter steps through the four digits, DIGIT_CYCLES clocks
// each; the selected BCD digit is decoded and registered together with its
// anode pattern (one cycle of latency). In adjust mode a blink counter
// toggles a phase every BLINK_CYCLES clocks, and during phase 1 the selected
// digit pair is blanked.
//   clk   : system clock
//   reset : synchronous, active-low
//   bus   : slave side of seg_display_mux_if (digits, adj/sel in; seg/ad out)
module seg_display_mux
  import seg_display_mux_pkg::*;
#(
  parameter int DIGIT_CYCLES = 100000,
  parameter int BLINK_CYCLES = 25000000
) (
  input  logic                clk,
  input  logic                reset,
  seg_display_mux_if.slave    bus
);

  localparam int RW = (DIGIT_CYCLES > 1) ? $clog2(DIGIT_CYCLES) : 1;
  localparam int BW = (BLINK_CYCLES > 1) ? $clog2(BLINK_CYCLES) : 1;
  localparam logic [RW-1:0] REFRESH_LAST = RW'(DIGIT_CYCLES - 1);
  localparam logic [BW-1:0] BLINK_LAST   = BW'(BLINK_CYCLES - 1);

  logic [RW-1:0] refresh_cnt;
  logic [BW-1:0] blink_cnt;
  logic          blink_phase;
  digit_idx_t    idx;
  logic [3:0]    cur_digit;
  logic [7:0]    dec_seg;
  logic          in_sel_pair;
  logic          blank;
  logic [7:0]    seg_q;
  logic [3:0]    ad_q;

  // Digit selected by the current scan index.
  always_comb begin
    cur_digit = bus.s0;
    case (idx)
      IDX_S0:  cur_digit = bus.s0;
      IDX_S1:  cur_digit = bus.s1;
      IDX_M0:  cur_digit = bus.m0;
      default: cur_digit = bus.m1;
    endcase
  end

  bcd_to_seg7 u_dec (
    .bcd (cur_digit),
    .seg (dec_seg)
  );

  // idx[1] separates the minutes pair (2,3) from the seconds pair (0,1).
  assign in_sel_pair = bus.sel ? ~idx[1] : idx[1];
  assign blank       = bus.adj & blink_phase & in_sel_pair;

  always_ff @(posedge clk) begin
    // NOTE: all state here uses non-blocking assignments so every register
    // samples the pre-edge values, regardless of statement order.
    if (!reset) begin
      refresh_cnt <= '0;
      idx         <= IDX_S0;
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
      seg_q       <= SEG_BLANK;
      ad_q        <= AN_OFF;
    end else begin
      if (refresh_cnt == REFRESH_LAST) begin
        refresh_cnt <= '0;
        idx         <= digit_idx_t'(idx + 2'd1);
      end else begin
        refresh_cnt <= refresh_cnt + RW'(1);
      end

      // Holding the blink state at zero outside adjust mode guarantees that
      // entering adjust mode starts with a visible half-period.
      if (!bus.adj) begin
        blink_cnt   <= '0;
        blink_phase <= 1'b0;
      end else if (blink_cnt == BLINK_LAST) begin
        blink_cnt   <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        blink_cnt   <= blink_cnt + BW'(1);
      end

      seg_q <= blank ? SEG_BLANK : dec_seg;
      ad_q  <= blank ? AN_OFF    : anode_of(idx);
    end
  end

  assign bus.seg = seg_q;
  assign bus.ad  = ad_q;

endmodule

// File: tb/tb_seg_display_mux.sv
// Directed testbench for seg_display_mux with DIGIT_CYCLES=4, BLINK_CYCLES=16.
// Inputs change 1 ns after a rising edge; outputs are sampled at that point.
module tb_seg_display_mux;

  logic clk;
  logic reset;
  int   tests_run;
  int   tests_failed;
  int   edge_cnt;   // output edges since reset release
  int   adj_cnt;    // consecutive edges with adj==1

  seg_display_mux_if bus ();

  seg_display_mux #(
    .DIGIT_CYCLES (4),
    .BLINK_CYCLES (16)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] seg_of(input logic [3:0] d);
    case (d)
      4'd0: return 8'hC0;
      4'd1: return 8'hF9;
      4'd2: return 8'hA4;
      4'd3: return 8'hB0;
      4'd4: return 8'h99;
      4'd5: return 8'h92;
      4'd6: return 8'h82;
      4'd7: return 8'hF8;
      4'd8: return 8'h80;
      4'd9: return 8'h90;
      default: return 8'hFF;
    endcase
  endfunction

  function automatic logic [3:0] an_of(input int i);
    case (i)
      0: return 4'b1110;
      1: return 4'b1101;
      2: return 4'b1011;
      default: return 4'b0111;
    endcase
  endfunction

  function automatic logic [3:0] digit_of(input int i);
    case (i)
      0: return bus.s0;
      1: return bus.s1;
      2: return bus.m0;
      default: return bus.m1;
    endcase
  endfunction

  // Computes what the next edge must register, then advances one clock.
  task automatic advance(output logic [3:0] ea, output logic [7:0] es);
    int   i;
    logic phase;
    logic blank;
    i     = (edge_cnt / 4) % 4;
    phase = ((adj_cnt / 16) % 2) == 1;
    blank = bus.adj && phase && (bus.sel ? (i < 2) : (i >= 2));
    ea    = blank ? 4'hF  : an_of(i);
    es    = blank ? 8'hFF : seg_of(digit_of(i));
    @(posedge clk);
    #1;
    edge_cnt++;
    adj_cnt = bus.adj ? adj_cnt + 1 : 0;
  endtask

  task automatic test_reset();
    reset   = 1'b0;
    bus.m1  = 4'd1;
    bus.m0  = 4'd2;
    bus.s1  = 4'd3;
    bus.s0  = 4'd4;
    bus.adj = 1'b0;
    bus.sel = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk);
      #1;
      tests_run++;
      if (bus.ad !== 4'b1111 || bus.seg !== 8'hFF) begin
        tests_failed++;
        $display("FAIL reset_hold cyc=%0d: ad=%b seg=%h, want ad=1111 seg=ff",
                 c, bus.ad, bus.seg);
      end
    end
    reset    = 1'b1;
    edge_cnt = 0;
    adj_cnt  = 0;
    @(posedge clk);
    #1;
    edge_cnt = 1;
    tests_run++;
    if (bus.ad !== 4'b1110 || bus.seg !== 8'h99) begin
      tests_failed++;
      $display("FAIL reset_release: ad=%b seg=%h, want ad=1110 seg=99",
               bus.ad, bus.seg);
    end
  endtask

  task automatic test_scan();
    logic [3:0] ea;
    logic [7:0] es;
    for (int c = 0; c < 32; c++) begin
      advance(ea, es);
      tests_run++;
      if (bus.ad !== ea || bus.seg !== es || $countones(~bus.ad) > 1) begin
        tests_failed++;
        $display("FAIL scan edge=%0d: ad=%b seg=%h, want ad=%b seg=%h",
                 edge_cnt, bus.ad, bus.seg, ea, es);
      end
    end
  endtask

  task automatic test_invalid_bcd();
    logic [3:0] ea;
    logic [7:0] es;
    int         blanks;
    blanks = 0;
    bus.s0 = 4'hC;
    for (int c = 0; c < 16; c++) begin
      advance(ea, es);
      if (bus.ad === 4'b1110 && bus.seg === 8'hFF) blanks++;
      tests_run++;
      if (bus.ad !== ea || bus.seg !== es) begin
        tests_failed++;
        $display("FAIL invalid_bcd edge=%0d: ad=%b seg=%h, want ad=%b seg=%h",
                 edge_cnt, bus.ad, bus.seg, ea, es);
      end
    end
    tests_run++;
    if (blanks != 4) begin
      tests_failed++;
      $display("FAIL invalid_bcd_slots: blank s0 slots=%0d, want 4", blanks);
    end
    bus.s0 = 4'd4;
  endtask

  task automatic test_blink();
    logic [3:0] ea;
    logic [7:0] es;
    int         offs;
    bus.adj = 1'b1;
    bus.sel = 1'b0;
    offs    = 0;
    for (int c = 0; c < 64; c++) begin
      if (c == 32) bus.sel = 1'b1;
      advance(ea, es);
      if (bus.ad === 4'b1111) offs++;
      tests_run++;
      if (bus.ad !== ea || bus.seg !== es) begin
        tests_failed++;
        $display("FAIL blink c=%0d sel=%0d: ad=%b seg=%h, want ad=%b seg=%h",
                 c, bus.sel, bus.ad, bus.seg, ea, es);
      end
      tests_run++;
      if (c < 16 && bus.ad === 4'b1111) begin
        tests_failed++;
        $display("FAIL blink_first_half c=%0d: ad=%b, want a digit lit", c, bus.ad);
      end
    end
    // Two blank half-periods of 16 edges, half of each in the selected pair.
    tests_run++;
    if (offs != 16) begin
      tests_failed++;
      $display("FAIL blink_blank_count: blanked=%0d, want 16", offs);
    end
  endtask

  task automatic test_adjust_exit();
    logic [3:0] ea;
    logic [7:0] es;
    int         n;
    bus.sel = 1'b0;
    n = 0;
    // Advance until a minutes slot in the blank half-period has been output.
    while (!(((adj_cnt - 1) / 16) % 2 == 1 && (((edge_cnt - 1) / 4) % 4) >= 2 &&
             bus.ad === 4'b1111) && n < 80) begin
      advance(ea, es);
      n++;
    end
    tests_run++;
    if (bus.ad !== 4'b1111 || bus.seg !== 8'hFF) begin
      tests_failed++;
      $display("FAIL adj_exit_blank: ad=%b seg=%h, want ad=1111 seg=ff",
               bus.ad, bus.seg);
    end
    bus.adj = 1'b0;
    advance(ea, es);
    tests_run++;
    if (bus.ad !== ea || bus.seg !== es || bus.ad === 4'b1111) begin
      tests_failed++;
      $display("FAIL adj_exit_show: ad=%b seg=%h, want ad=%b seg=%h",
               bus.ad, bus.seg, ea, es);
    end
    bus.adj = 1'b1;
    for (int c = 0; c < 16; c++) begin
      advance(ea, es);
      tests_run++;
      if (bus.ad !== ea || bus.seg !== es || bus.ad === 4'b1111) begin
        tests_failed++;
        $display("FAIL adj_reenter c=%0d: ad=%b seg=%h, want ad=%b seg=%h",
                 c, bus.ad, bus.seg, ea, es);
      end
    end
    bus.adj = 1'b0;
    advance(ea, es);
  endtask

  task automatic test_reset_mid_scan();
    logic [3:0] ea;
    logic [7:0] es;
    int         n;
    n = 0;
    while (!((edge_cnt / 4) % 4 == 2 && edge_cnt % 4 == 1) && n < 32) begin
      advance(ea, es);
      n++;
    end
    tests_run++;
    if (bus.ad !== 4'b1011) begin
      tests_failed++;
      $display("FAIL mid_scan_slot: ad=%b, want 1011", bus.ad);
    end
    reset = 1'b0;
    @(posedge clk);
    #1;
    tests_run++;
    if (bus.ad !== 4'b1111 || bus.seg !== 8'hFF) begin
      tests_failed++;
      $display("FAIL mid_scan_reset: ad=%b seg=%h, want ad=1111 seg=ff",
               bus.ad, bus.seg);
    end
    reset    = 1'b1;
    edge_cnt = 0;
    adj_cnt  = 0;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      #1;
      tests_run++;
      if (bus.ad !== ((c < 4) ? 4'b1110 : 4'b1101) ||
          bus.seg !== ((c < 4) ? 8'h99 : 8'hB0)) begin
        tests_failed++;
        $display("FAIL restart c=%0d: ad=%b seg=%h, want ad=%b seg=%h",
                 c, bus.ad, bus.seg, (c < 4) ? 4'b1110 : 4'b1101,
                 (c < 4) ? 8'h99 : 8'hB0);
      end
    end
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    edge_cnt     = 0;
    adj_cnt      = 0;
    test_reset();
    test_scan();
    test_invalid_bcd();
    test_blink();
    test_adjust_exit();
    test_reset_mid_scan();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
